// File: rtl/db4_poly_sched_pkg.sv
// Shared definitions for the DB4 polyphase scheduler: controller states,
// channel encodings and default widths/latency.
package db4_poly_sched_pkg;

   localparam int DEF_DW  = 8;
   localparam int DEF_YW  = 9;
   localparam int DEF_LAT = 2;
   localparam int CNT_W   = 4;

   localparam logic CH_A = 1'b0;
   localparam logic CH_B = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_HOLD
   } state_t;

   // Round-robin pick: a tie goes to the channel that did not win last time.
   function automatic logic rr_pick(input logic full_a, input logic full_b, input logic last);
      if (full_a && full_b) return ~last;
      return full_a ? CH_A : CH_B;
   endfunction

endpackage

// File: rtl/db4_poly_sched_pair_collect.sv
// Per-channel pair collector: gathers an even then an odd sample and
// refuses further samples until the pair is handed off.
module pair_collect
   import db4_poly_sched_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] data,
   input  logic          valid,
   input  logic          clear,
   output logic          ready,
   output logic          full,
   output logic [DW-1:0] even,
   output logic [DW-1:0] odd
);

   logic phase;

   assign ready = ~full;

   // clear only arrives while full, so it never collides with an accept
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         even  <= '0;
         odd   <= '0;
         phase <= 1'b0;
         full  <= 1'b0;
      end else begin
         if (clear) full <= 1'b0;
         if (valid && !full) begin
            if (!phase) begin
               even  <= data;
               phase <= 1'b1;
            end else begin
               odd   <= data;
               phase <= 1'b0;
               full  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/db4_poly_sched.sv
// Two-channel scheduler that feeds full even/odd sample pairs into a shared
// fixed-latency polyphase filter core and holds each result for a handshake.
module db4_poly_sched
   import db4_poly_sched_pkg::*;
#(
   parameter int DW  = DEF_DW,
   parameter int YW  = DEF_YW,
   parameter int LAT = DEF_LAT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] a_data,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [DW-1:0] b_data,
   input  logic          b_valid,
   output logic          b_ready,
   output logic          fil_start,
   output logic [DW-1:0] fil_even,
   output logic [DW-1:0] fil_odd,
   output logic          fil_chan,
   input  logic [YW-1:0] fil_y,
   output logic [YW-1:0] y_data,
   output logic          y_chan,
   output logic          y_valid,
   input  logic          y_ready
);

   state_t           state, state_next;
   logic             a_full, b_full;
   logic [DW-1:0]    a_even, a_odd, b_even, b_odd;
   logic             clr_a, clr_b;
   logic             grant, last_grant;
   logic             load, capture;
   logic [CNT_W-1:0] cnt;

   pair_collect #(.DW(DW)) u_col_a (
      .clk   (clk),
      .reset (reset),
      .data  (a_data),
      .valid (a_valid),
      .clear (clr_a),
      .ready (a_ready),
      .full  (a_full),
      .even  (a_even),
      .odd   (a_odd)
   );

   pair_collect #(.DW(DW)) u_col_b (
      .clk   (clk),
      .reset (reset),
      .data  (b_data),
      .valid (b_valid),
      .clear (clr_b),
      .ready (b_ready),
      .full  (b_full),
      .even  (b_even),
      .odd   (b_odd)
   );

   assign grant = rr_pick(a_full, b_full, last_grant);
   assign clr_a = fil_start && (fil_chan == CH_A);
   assign clr_b = fil_start && (fil_chan == CH_B);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      fil_start  = 1'b0;
      y_valid    = 1'b0;
      load       = 1'b0;
      capture    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (a_full || b_full) begin
               load       = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            fil_start  = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               capture    = 1'b1;
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            y_valid = 1'b1;
            if (y_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Operands stay latched until the next grant; the result only moves on capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fil_even   <= '0;
         fil_odd    <= '0;
         fil_chan   <= CH_A;
         last_grant <= CH_B;
         cnt        <= '0;
         y_data     <= '0;
         y_chan     <= CH_A;
      end else begin
         if (load) begin
            fil_even   <= (grant == CH_B) ? b_even : a_even;
            fil_odd    <= (grant == CH_B) ? b_odd  : a_odd;
            fil_chan   <= grant;
            last_grant <= grant;
         end
         if (fil_start) cnt <= CNT_W'(LAT - 1);
         else if (state == ST_WAIT && cnt != '0) cnt <= cnt - 1'b1;
         if (capture) begin
            y_data <= fil_y;
            y_chan <= fil_chan;
         end
      end
   end

endmodule

// File: tb/tb_db4_poly_sched.sv
// Randomized self-checking bench for db4_poly_sched, with a transaction-level
// model of the collectors, the round-robin scheduler and a behavioural filter core.
module tb_db4_poly_sched;
   import db4_poly_sched_pkg::*;

   localparam int DW  = 8;
   localparam int YW  = 9;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] a_data, b_data;
   logic          a_valid, b_valid, a_ready, b_ready;
   logic          fil_start, fil_chan;
   logic [DW-1:0] fil_even, fil_odd;
   logic [YW-1:0] fil_y, y_data;
   logic          y_chan, y_valid, y_ready;

   always #5 clk = ~clk;

   db4_poly_sched #(.DW(DW), .YW(YW), .LAT(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .a_data    (a_data),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .b_data    (b_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .fil_start (fil_start),
      .fil_even  (fil_even),
      .fil_odd   (fil_odd),
      .fil_chan  (fil_chan),
      .fil_y     (fil_y),
      .y_data    (y_data),
      .y_chan    (y_chan),
      .y_valid   (y_valid),
      .y_ready   (y_ready)
   );

   logic [DW-1:0] qa[$], qb[$], a_script[$], b_script[$];
   int            cyc, n_checks, n_fail;
   int            start_cyc, pend_cyc, idle_from;
   bit            busy;
   logic          last_chan, pend_chan, cur_chan;
   logic [DW-1:0] cur_even, cur_odd;
   logic [YW-1:0] exp_y;

   function automatic logic [YW-1:0] core_fn(input logic [DW-1:0] e, input logic [DW-1:0] o, input logic ch);
      int s;
      s = int'($signed(e)) + int'($signed(o)) + (ch ? 3 : 0);
      return YW'(s);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic resetModel();
      qa.delete(); qb.delete(); a_script.delete(); b_script.delete();
      busy = 1'b0; pend_cyc = -1; idle_from = 0; last_chan = CH_B;
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
      resetModel();
      repeat (2) @(negedge clk);
      checkOutput("rst_a_ready", a_ready, 1);
      checkOutput("rst_b_ready", b_ready, 1);
      checkOutput("rst_fil_start", fil_start, 0);
      checkOutput("rst_fil_even", fil_even, 0);
      checkOutput("rst_fil_odd", fil_odd, 0);
      checkOutput("rst_fil_chan", fil_chan, 0);
      checkOutput("rst_y_valid", y_valid, 0);
      checkOutput("rst_y_data", y_data, 0);
      checkOutput("rst_y_chan", y_chan, 0);
      reset = 1'b0;
   endtask

   // One call per cycle group: check this cycle's outputs, then drive the next inputs.
   task automatic applyStimulus(input int n, input int a_pct, input int b_pct, input int yr_pct);
      logic exp_ra, exp_rb, exp_yv;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         exp_ra = (qa.size() < 2);
         exp_rb = (qb.size() < 2);
         checkOutput("a_ready", a_ready, exp_ra);
         checkOutput("b_ready", b_ready, exp_rb);
         if (pend_cyc == cyc) begin
            checkOutput("fil_start", fil_start, 1);
            cur_chan = pend_chan;
            if (cur_chan == CH_A) begin
               cur_even = qa.pop_front(); cur_odd = qa.pop_front();
            end else begin
               cur_even = qb.pop_front(); cur_odd = qb.pop_front();
            end
            exp_y     = core_fn(cur_even, cur_odd, cur_chan);
            busy      = 1'b1;
            start_cyc = cyc;
            pend_cyc  = -1;
         end else begin
            checkOutput("fil_start", fil_start, 0);
         end
         if (busy) begin
            checkOutput("fil_chan", fil_chan, cur_chan);
            checkOutput("fil_even", fil_even, cur_even);
            checkOutput("fil_odd", fil_odd, cur_odd);
         end
         exp_yv = busy && (cyc >= start_cyc + LAT + 1);
         checkOutput("y_valid", y_valid, exp_yv);
         if (exp_yv) begin
            checkOutput("y_data", y_data, exp_y);
            checkOutput("y_chan", y_chan, cur_chan);
         end
         y_ready = ($urandom_range(99) < yr_pct);
         if (exp_yv && y_ready) begin
            busy      = 1'b0;
            idle_from = cyc + 1;
         end
         if (!busy && pend_cyc < 0 && cyc >= idle_from && (qa.size() == 2 || qb.size() == 2)) begin
            if (qa.size() == 2 && qb.size() == 2) pend_chan = ~last_chan;
            else                                  pend_chan = (qa.size() == 2) ? CH_A : CH_B;
            last_chan = pend_chan;
            pend_cyc  = cyc + 1;
         end
         fil_y = (busy && cyc == start_cyc + LAT) ? exp_y : YW'($urandom);
         if (a_script.size() > 0) begin
            a_valid = 1'b1; a_data = a_script[0];
         end else begin
            a_valid = ($urandom_range(99) < a_pct); a_data = DW'($urandom);
         end
         if (a_valid && exp_ra) begin
            qa.push_back(a_data);
            if (a_script.size() > 0) void'(a_script.pop_front());
         end
         if (b_script.size() > 0) begin
            b_valid = 1'b1; b_data = b_script[0];
         end else begin
            b_valid = ($urandom_range(99) < b_pct); b_data = DW'($urandom);
         end
         if (b_valid && exp_rb) begin
            qb.push_back(b_data);
            if (b_script.size() > 0) void'(b_script.pop_front());
         end
      end
   endtask

   initial begin
      reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
      a_data = '0; b_data = '0; fil_y = '0;
      cyc = 0; n_checks = 0; n_fail = 0;
      resetModel();
      doReset();

      $display("[TB] single pair on A");
      a_script = '{8'd10, 8'd20};
      applyStimulus(12, 0, 0, 100);

      $display("[TB] both pairs full, alternation");
      a_script = '{8'd1, 8'd2};
      b_script = '{8'd3, 8'd4};
      applyStimulus(20, 0, 0, 100);
      a_script = '{8'd5, 8'd6};
      b_script = '{8'd7, 8'd8};
      applyStimulus(20, 0, 0, 100);

      $display("[TB] result held with y_ready low");
      a_script = '{8'hF0, 8'h7F};
      b_script = '{8'h11, 8'h22};
      applyStimulus(15, 0, 0, 0);
      applyStimulus(20, 0, 0, 100);

      $display("[TB] odd sample count on A");
      a_script = '{8'd30, 8'd40, 8'd50};
      applyStimulus(15, 0, 0, 100);

      $display("[TB] random traffic");
      applyStimulus(2000, 40, 40, 60);
      applyStimulus(500, 90, 90, 20);
      applyStimulus(20, 0, 0, 100);

      $display("[TB] reset during wait");
      doReset();
      a_script = '{8'd9, 8'd99};
      begin
         bit reached;
         reached = 1'b0;
         for (int k = 0; k < 40 && !reached; k++) begin
            applyStimulus(1, 0, 0, 100);
            if (busy && cyc == start_cyc + 1) reached = 1'b1;
         end
         checkOutput("reach_wait", reached, 1);
      end
      doReset();
      a_script = '{8'd11, 8'd12};
      applyStimulus(20, 0, 0, 100);
      applyStimulus(300, 50, 50, 50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
